// File: rtl/bram_xfer_engine.sv
// bram_xfer_engine: copy / fill / verify engine driving a single-port-per-direction BRAM.
// Define XFER_ABORT_EN to add an abort input that ends a running transfer early.
module bram_xfer_engine #(
   parameter int a_bits = 14
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
`ifdef XFER_ABORT_EN
   input  logic              abort,
`endif
   input  logic [1:0]        op,
   input  logic [a_bits-1:0] src_addr,
   input  logic [a_bits-1:0] dst_addr,
   input  logic [a_bits:0]   length,
   input  logic [7:0]        pattern,
   output logic              busy,
   output logic              done,
   output logic              mismatch,
   output logic [a_bits-1:0] mismatch_addr,
   output logic [a_bits-1:0] mem_read_addr,
   output logic [a_bits-1:0] mem_write_addr,
   output logic              mem_read_strobe,
   output logic              mem_write_strobe,
   output logic [7:0]        mem_write_data,
   input  logic [7:0]        mem_read_data
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
   state_t state, nxt;
   logic [1:0] op_q, op_eff;
   logic [7:0] pattern_q;
   logic [a_bits:0] cnt, cnt_n;
   logic cmp_valid, cmp_valid_n;
   logic [a_bits-1:0] cmp_addr, rd_addr_n, wr_addr_n;
   logic abort_i, accept, bad, mm_set, nxt_busy, issue_n, rd_n, wr_n;
`ifdef XFER_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif
   assign accept = state == IDLE && start;
   assign bad = cmp_valid && mem_read_data != pattern_q;
   assign mm_set = bad && !abort_i;
   // copy data is forwarded from the read port so each write lands in the cycle its byte is valid
   assign mem_write_data = !mem_write_strobe ? 8'h00 : op_q == 2'b00 ? mem_read_data : pattern_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = !start ? IDLE : length == '0 ? FINISH : RUN;
         RUN:     nxt = abort_i || bad ? FINISH : cnt != '0 ? RUN : op_q[0] ? FINISH : DRAIN;
         DRAIN:   nxt = FINISH;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      op_eff = accept ? op : op_q;
      nxt_busy = nxt == RUN || nxt == DRAIN;
      issue_n = accept ? length != '0 : state == RUN && nxt == RUN;
      rd_n = issue_n && !op_eff[0];
      wr_n = op_eff[0] ? issue_n : mem_read_strobe && op_q == 2'b00 && nxt_busy;
      rd_addr_n = accept ? src_addr : rd_n && mem_read_strobe ? mem_read_addr + a_bits'(1) : mem_read_addr;
      wr_addr_n = accept ? dst_addr : wr_n && mem_write_strobe ? mem_write_addr + a_bits'(1) : mem_write_addr;
      cnt_n = accept ? length - (a_bits+1)'(1) : issue_n ? cnt - (a_bits+1)'(1) : cnt;
      cmp_valid_n = mem_read_strobe && op_q == 2'b10 && nxt_busy;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         op_q             <= 2'b00;
         pattern_q        <= 8'h00;
         cnt              <= '0;
         cmp_valid        <= 1'b0;
         cmp_addr         <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         mismatch         <= 1'b0;
         mismatch_addr    <= '0;
         mem_read_addr    <= '0;
         mem_write_addr   <= '0;
         mem_read_strobe  <= 1'b0;
         mem_write_strobe <= 1'b0;
      end else begin
         op_q             <= op_eff;
         pattern_q        <= accept ? pattern : pattern_q;
         cnt              <= cnt_n;
         cmp_valid        <= cmp_valid_n;
         cmp_addr         <= mem_read_addr;
         busy             <= nxt_busy;
         done             <= nxt == FINISH;
         mismatch         <= accept ? 1'b0 : mm_set ? 1'b1 : mismatch;
         mismatch_addr    <= accept ? '0 : mm_set ? cmp_addr : mismatch_addr;
         mem_read_addr    <= rd_addr_n;
         mem_write_addr   <= wr_addr_n;
         mem_read_strobe  <= rd_n;
         mem_write_strobe <= wr_n;
      end
endmodule

// File: doc/bram_xfer_engine.md
BRAM_XFER_ENGINE -- requirements
Module: bram_xfer_engine

Interface
REQ-001 SHALL have parameter: a_bits, 14, BRAM address width in bits.
REQ-002 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  in  1  command strobe; sampled only while idle.
REQ-005 SHALL have port: op  in  2  operation: 00 copy, 01 fill, 10 verify, 11 reserved (treated as fill).
REQ-006 SHALL have port: src_addr  in  a_bits  copy/verify source start address.
REQ-007 SHALL have port: dst_addr  in  a_bits  copy/fill destination start address.
REQ-008 SHALL have port: length  in  a_bits+1  byte count; 0 means no transfer.
REQ-009 SHALL have port: pattern  in  8  fill byte / verify expected byte.
REQ-010 SHALL have port: busy  out  1  transfer in progress.
REQ-011 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: mismatch  out  1  verify failure flag.
REQ-013 SHALL have port: mismatch_addr  out  a_bits  address of first failing byte.
REQ-014 SHALL have port: mem_read_addr, mem_write_addr  out  a_bits each  BRAM addresses.
REQ-015 SHALL have port: mem_read_strobe, mem_write_strobe  out  1 each  BRAM strobes.
REQ-016 SHALL have port: mem_write_data  out  8  BRAM write data.
REQ-017 SHALL have port: mem_read_data  in  8  BRAM read data, valid the cycle after a read strobe.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN, FINISH; start in IDLE latches all command inputs and enters RUN; start outside IDLE SHALL be ignored.
REQ-019 SHALL, when length==0, go IDLE->FINISH with no strobes.
REQ-020 Copy SHALL assert mem_read_strobe for N cycles (cycles 1..N after start), addresses src_addr+i, and mem_write_strobe in cycles 2..N+1 at dst_addr+i with mem_write_data = mem_read_data.
REQ-021 Fill SHALL assert mem_write_strobe in cycles 1..N at dst_addr+i with data=pattern; no read strobes.
REQ-022 Verify SHALL read src_addr+i in cycles 1..N and compare each returned byte to pattern the following cycle; no write strobes.
REQ-023 On first verify mismatch SHALL set mismatch=1, mismatch_addr=failing address, stop issuing reads that cycle, discard any in-flight data, enter FINISH.
REQ-024 RUN->DRAIN after last read (copy/verify); DRAIN covers final write/compare; DRAIN->FINISH; FINISH pulses done for one cycle and returns to IDLE.
REQ-025 busy SHALL be high exactly in RUN and DRAIN; done and busy SHALL never be high together.
REQ-026 All addresses SHALL wrap modulo 2^a_bits; length 2^a_bits SHALL touch every address once.
REQ-027 Copy SHALL proceed strictly ascending; overlapping regions with dst>src SHALL replicate source bytes (defined, not an error).
REQ-028 mismatch/mismatch_addr SHALL hold until the next accepted start, which clears them.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, busy=0, done=0, both strobes=0, mismatch=0, all addresses and data 0; an in-progress transfer is abandoned without done.

Configuration
REQ-031 With XFER_ABORT_EN defined, an input abort (1 bit) SHALL exist; abort in RUN/DRAIN SHALL deassert strobes next cycle and enter FINISH (done pulses, mismatch unchanged).
REQ-032 Without XFER_ABORT_EN, no abort port SHALL exist and every transfer runs to completion.

Verification
REQ-033 Copy src=0x0010 dst=0x0100 len=4 with BRAM model -> reads cycles 1-4, writes 2-5, done cycle 6, dst bytes equal src.
REQ-034 Fill dst=0x3FFE len=4 pattern=0xA5 -> writes 0x3FFE,0x3FFF,0x0000,0x0001 (a_bits=14), done cycle 5.
REQ-035 Verify src=0x0200 len=8 pattern=0x00, byte 0x0203=0x7F -> mismatch=1, mismatch_addr=0x0203, no read past 0x0204, done one cycle later.
REQ-036 length=0 start -> done cycle 1, no strobes; start while busy -> ignored, original transfer unaffected.
REQ-037 reset_n low during copy cycle 3 -> strobes low immediately, no done; with XFER_ABORT_EN, abort in cycle 3 -> done pulse, no further strobes.
